// File: rtl/valid_ready_round_robin_arbiter.sv
// Packet-aware round-robin arbiter: CHANNELS valid-ready requesters share one
// registered valid-ready output; a granted channel owns the sink until its last beat.
module valid_ready_round_robin_arbiter #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  localparam int CHANNEL_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [CHANNELS*WIDTH-1:0]   input_data,
  input  logic [CHANNELS-1:0]         input_last,
  input  logic [CHANNELS-1:0]         input_valid,
  output logic [CHANNELS-1:0]         input_ready,
  output logic [WIDTH-1:0]            output_data,
  output logic                        output_last,
  output logic [CHANNEL_WIDTH-1:0]    output_channel,
  output logic                        output_valid,
  input  logic                        output_ready
);

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  localparam logic [CHANNEL_WIDTH-1:0] LAST_CHANNEL = CHANNEL_WIDTH'(CHANNELS - 1);

  state_t                   state_r;
  logic [CHANNEL_WIDTH-1:0] lock_channel_r;
  logic [CHANNEL_WIDTH-1:0] pointer_r;

  logic                     high_found_s;
  logic [CHANNEL_WIDTH-1:0] high_channel_s;
  logic                     low_found_s;
  logic [CHANNEL_WIDTH-1:0] low_channel_s;
  logic                     grant_valid_s;
  logic [CHANNEL_WIDTH-1:0] grant_channel_s;
  logic [WIDTH-1:0]         grant_data_s;
  logic                     grant_last_s;
  logic                     stage_free_s;
  logic                     transfer_s;
  logic [CHANNEL_WIDTH-1:0] next_pointer_s;

  // Grant selection: the wrap-around search is split into the slice at/above the
  // pointer (preferred) and a plain lowest-index fallback over all channels.
  always_comb begin
    high_found_s   = 1'b0;
    high_channel_s = '0;
    low_found_s    = 1'b0;
    low_channel_s  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      high_channel_s = (!high_found_s && input_valid[i] && (CHANNEL_WIDTH'(i) >= pointer_r))
                       ? CHANNEL_WIDTH'(i) : high_channel_s;
      high_found_s   = high_found_s | (input_valid[i] & (CHANNEL_WIDTH'(i) >= pointer_r));
      low_channel_s  = (!low_found_s && input_valid[i]) ? CHANNEL_WIDTH'(i) : low_channel_s;
      low_found_s    = low_found_s | input_valid[i];
    end
    if (state_r == LOCKED) begin
      grant_valid_s   = input_valid[lock_channel_r];
      grant_channel_s = lock_channel_r;
    end else begin
      grant_valid_s   = high_found_s | low_found_s;
      grant_channel_s = high_found_s ? high_channel_s : low_channel_s;
    end
  end

  // Data/last mux for the granted channel and the per-channel ready fan-out.
  always_comb begin
    grant_data_s = '0;
    grant_last_s = 1'b0;
    input_ready  = '0;
    stage_free_s = ~output_valid | output_ready;
    transfer_s   = grant_valid_s & stage_free_s;
    for (int i = 0; i < CHANNELS; i++) begin
      grant_data_s   = (grant_channel_s == CHANNEL_WIDTH'(i)) ? input_data[i*WIDTH +: WIDTH] : grant_data_s;
      grant_last_s   = (grant_channel_s == CHANNEL_WIDTH'(i)) ? input_last[i] : grant_last_s;
      input_ready[i] = transfer_s & resetn & (grant_channel_s == CHANNEL_WIDTH'(i));
    end
    next_pointer_s = (grant_channel_s == LAST_CHANNEL) ? '0 : grant_channel_s + CHANNEL_WIDTH'(1);
  end

  // Output register: load on a transfer, drain when the sink accepts, hold under backpressure.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      output_valid   <= 1'b0;
      output_data    <= '0;
      output_last    <= 1'b0;
      output_channel <= '0;
    end else if (transfer_s) begin
      output_valid   <= 1'b1;
      output_data    <= grant_data_s;
      output_last    <= grant_last_s;
      output_channel <= grant_channel_s;
    end else if (output_ready) begin
      output_valid   <= 1'b0;
    end else begin
      output_valid   <= output_valid;
    end
  end

  // Lock/pointer state machine, advanced only by a beat actually transferred.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r        <= UNLOCKED;
      lock_channel_r <= '0;
      pointer_r      <= '0;
    end else if (transfer_s) begin
      case (state_r)
        UNLOCKED: begin
          if (grant_last_s) begin
            pointer_r <= next_pointer_s;
          end else begin
            state_r        <= LOCKED;
            lock_channel_r <= grant_channel_s;
          end
        end
        LOCKED: begin
          if (grant_last_s) begin
            state_r   <= UNLOCKED;
            pointer_r <= next_pointer_s;
          end else begin
            state_r   <= LOCKED;
          end
        end
        default: begin
          state_r <= UNLOCKED;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: tb/tb_valid_ready_round_robin_arbiter.sv
// Randomised and directed bench for valid_ready_round_robin_arbiter: a queue-based
// requester/arbitration model, a per-channel scoreboard and a CHANNELS=3 wrap check.
module tb_valid_ready_round_robin_arbiter;
  localparam int W = 8;
  localparam int C = 4;
  localparam int DEPTH = 64;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [C*W-1:0] input_data;
  logic [C-1:0]   input_last, input_valid, input_ready;
  logic [W-1:0]   output_data;
  logic           output_last, output_valid, output_ready;
  logic [1:0]     output_channel;

  logic [3*W-1:0] d3;
  logic [2:0]     l3, v3, r3;
  logic [W-1:0]   od3;
  logic           ol3, ov3, ordy3;
  logic [1:0]     oc3;

  valid_ready_round_robin_arbiter #(.WIDTH(W), .CHANNELS(C)) dut (
    .clock(clock), .resetn(resetn),
    .input_data(input_data), .input_last(input_last), .input_valid(input_valid),
    .input_ready(input_ready),
    .output_data(output_data), .output_last(output_last), .output_channel(output_channel),
    .output_valid(output_valid), .output_ready(output_ready)
  );

  valid_ready_round_robin_arbiter #(.WIDTH(W), .CHANNELS(3)) dut3 (
    .clock(clock), .resetn(resetn),
    .input_data(d3), .input_last(l3), .input_valid(v3), .input_ready(r3),
    .output_data(od3), .output_last(ol3), .output_channel(oc3),
    .output_valid(ov3), .output_ready(ordy3)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // requester queues (beat = {last, data}) and beats accepted by the arbiter, per channel
  logic [8:0] src_buf [C][DEPTH];
  int         src_head [C];
  int         src_tail [C];
  logic [8:0] exp_buf [C][DEPTH];
  int         exp_head [C];
  int         exp_tail [C];
  int         pend_len [C];

  // abstract model of the arbiter
  int         m_ov, m_lock, m_ptr, m_chan;
  logic [W-1:0] m_data;
  logic       m_last;
  int         owner;
  int         acc_log[$];
  int         acc_data[$];
  bit         rand_mode = 1'b0;
  bit         single_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit has_beat(input int c);
    return src_head[c] != src_tail[c];
  endfunction

  task automatic push_src(input int c, input logic [7:0] data, input logic last);
    src_buf[c][src_tail[c] % DEPTH] = {last, data};
    src_tail[c]++;
  endtask

  task automatic drive_inputs();
    logic [8:0] beat;
    for (int c = 0; c < C; c++) begin
      beat = src_buf[c][src_head[c] % DEPTH];
      input_valid[c] = has_beat(c);
      input_data[c*W +: W] = beat[7:0];
      input_last[c] = beat[8];
    end
  endtask

  task automatic clear_bench();
    for (int c = 0; c < C; c++) begin
      src_head[c] = 0; src_tail[c] = 0; exp_head[c] = 0; exp_tail[c] = 0; pend_len[c] = 0;
      for (int j = 0; j < DEPTH; j++) begin
        src_buf[c][j] = 9'd0;
        exp_buf[c][j] = 9'd0;
      end
    end
    m_ov = 0; m_lock = -1; m_ptr = 0; m_chan = 0; m_data = 8'd0; m_last = 1'b0; owner = -1;
  endtask

  // one clock: compare at negedge against the model, then advance model and requesters
  task automatic step();
    int g, idx, c;
    bit sf, fire;
    logic [8:0] beat;
    logic [8:0] fired_beat;
    logic [C-1:0] exp_rdy;
    @(negedge clock);
    g = -1;
    if (m_lock >= 0) begin
      if (has_beat(m_lock)) g = m_lock;
    end else begin
      for (int k = 0; k < C; k++) begin
        idx = (m_ptr + k) % C;
        if (g < 0 && has_beat(idx)) g = idx;
      end
    end
    sf = (m_ov == 0) || output_ready;
    fire = (g >= 0) && sf;
    exp_rdy = fire ? C'(1 << g) : '0;
    check("input_ready", 32'(input_ready), 32'(exp_rdy));
    check("output_valid", 32'(output_valid), 32'(m_ov));
    if (m_ov != 0) begin
      check("output_data", 32'(output_data), 32'(m_data));
      check("output_last", 32'(output_last), 32'(m_last));
      check("output_channel", 32'(output_channel), 32'(m_chan));
    end
    fired_beat = fire ? src_buf[g][src_head[g] % DEPTH] : 9'd0;
    if (output_valid && output_ready) begin
      c = int'(output_channel);
      acc_log.push_back(c);
      acc_data.push_back(int'(output_data));
      if (owner >= 0) check("packet_unbroken", 32'(c), 32'(owner));
      if (exp_head[c] == exp_tail[c]) begin
        check("beat_expected", 32'(exp_tail[c] - exp_head[c]), 32'd1);
      end else begin
        beat = exp_buf[c][exp_head[c] % DEPTH];
        exp_head[c]++;
        check("sb_data", 32'(output_data), 32'(beat[7:0]));
        check("sb_last", 32'(output_last), 32'(beat[8]));
      end
      owner = output_last ? -1 : c;
    end
    @(posedge clock);
    #1;
    if (fire) begin
      src_head[g]++;
      exp_buf[g][exp_tail[g] % DEPTH] = fired_beat;
      exp_tail[g]++;
      m_ov = 1; m_data = fired_beat[7:0]; m_last = fired_beat[8]; m_chan = g;
      if (fired_beat[8]) begin
        m_lock = -1;
        m_ptr = (g + 1) % C;
      end else begin
        m_lock = g;
      end
    end else if (output_ready) begin
      m_ov = 0;
    end
    for (int k = 0; k < C; k++) begin
      if (rand_mode && pend_len[k] == 0 && !has_beat(k) && $urandom_range(0, 3) == 0)
        pend_len[k] = $urandom_range(1, 4);
      if (pend_len[k] > 0 && $urandom_range(0, 1) == 1) begin
        push_src(k, 8'($urandom), pend_len[k] == 1);
        pend_len[k]--;
      end
      if (single_mode && !has_beat(k)) push_src(k, 8'($urandom), 1'b1);
    end
    if (rand_mode) output_ready = ($urandom_range(0, 3) != 0);
    drive_inputs();
  endtask

  task automatic reset_mid();
    @(negedge clock);
    resetn = 1'b0;
    #1;
    check("rst_output_valid", 32'(output_valid), 32'd0);
    check("rst_output_data", 32'(output_data), 32'd0);
    check("rst_output_last", 32'(output_last), 32'd0);
    check("rst_output_channel", 32'(output_channel), 32'd0);
    check("rst_input_ready", 32'(input_ready), 32'd0);
    clear_bench();
    drive_inputs();
    @(posedge clock); #1;
    @(posedge clock); #1;
    resetn = 1'b1;
  endtask

  task automatic check_drained(input string name);
    int outstanding;
    outstanding = 0;
    for (int c = 0; c < C; c++)
      outstanding += (src_tail[c] - src_head[c]) + (exp_tail[c] - exp_head[c]) + pend_len[c];
    check(name, 32'(outstanding), 32'd0);
    check("drained_output_valid", 32'(output_valid), 32'd0);
  endtask

  int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
  int exp_lock[5] = '{1, 1, 1, 3, 0};

  initial begin
    output_ready = 1'b1;
    d3 = 24'h332211; l3 = 3'b111; v3 = 3'b000; ordy3 = 1'b1;
    clear_bench();
    drive_inputs();
    reset_mid();

    // CHANNELS=3 wrap: ch1 last beat moves pointer to 2, ch0 alone wins, pointer -> 1
    v3 = 3'b010;
    @(negedge clock); check("wrap_rdy_ch1", 32'(r3), 32'b010);
    @(posedge clock); #1; v3 = 3'b001;
    @(negedge clock); check("wrap_grant_ch0", 32'(r3), 32'b001);
    check("wrap_out_ch1", 32'(oc3), 32'd1);
    @(posedge clock); #1; v3 = 3'b000;
    @(negedge clock); check("wrap_out_ch0", 32'(oc3), 32'd0);
    check("wrap_out_data", 32'(od3), 32'h11);
    v3 = 3'b111; #1;
    check("wrap_ptr_is_1", 32'(r3), 32'b010);
    @(posedge clock); #1; v3 = 3'b000;

    // round robin over always-valid single-beat packets
    reset_mid();
    acc_log.delete();
    for (int c = 0; c < C; c++) push_src(c, 8'(16 * c), 1'b1);
    drive_inputs();
    single_mode = 1'b1;
    repeat (7) step();
    single_mode = 1'b0;
    repeat (8) step();
    check("rr_count", 32'(acc_log.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < acc_log.size(); i++) check("rr_order", 32'(acc_log[i]), 32'(exp_rr[i]));
    check_drained("rr_drained");

    // packet lock: pointer set to 1, then ch1 3-beat packet with ch0 and ch3 pending
    reset_mid();
    push_src(0, 8'h30, 1'b1);
    drive_inputs();
    repeat (4) step();
    acc_log.delete();
    push_src(0, 8'h01, 1'b1);
    push_src(1, 8'h11, 1'b0); push_src(1, 8'h12, 1'b0); push_src(1, 8'h13, 1'b1);
    push_src(3, 8'h33, 1'b1);
    drive_inputs();
    repeat (10) step();
    check("lock_count", 32'(acc_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < acc_log.size(); i++) check("lock_order", 32'(acc_log[i]), 32'(exp_lock[i]));

    // backpressure: hold for five cycles, then release with nothing lost or doubled
    reset_mid();
    acc_data.delete();
    for (int i = 0; i < 5; i++) push_src(2, 8'(8'hA0 + i), 1'b1);
    drive_inputs();
    step();
    output_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", 32'(output_valid), 32'd1);
      check("bp_data", 32'(output_data), 32'hA0);
      check("bp_channel", 32'(output_channel), 32'd2);
      check("bp_input_ready", 32'(input_ready), 32'd0);
    end
    output_ready = 1'b1;
    repeat (10) step();
    check("bp_count", 32'(acc_data.size()), 32'd5);
    for (int i = 0; i < 5 && i < acc_data.size(); i++) check("bp_data_order", 32'(acc_data[i]), 32'(8'hA0 + i));
    check_drained("bp_drained");

    // random traffic, then reset mid-traffic, then a long random run
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    reset_mid();
    output_ready = 1'b1;
    acc_log.delete();
    for (int c = 0; c < C; c++) push_src(c, 8'(c), 1'b1);
    drive_inputs();
    repeat (6) step();
    check("post_reset_first_ch0", 32'(acc_log.size() > 0 ? acc_log[0] : -1), 32'd0);
    rand_mode = 1'b1;
    repeat (10000) step();
    rand_mode = 1'b0;
    output_ready = 1'b1;
    repeat (60) step();
    check_drained("random_drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
